// File: rtl/wb_burst_ram_if.sv
// Wishbone B3 bus bundle for the burst RAM slave.
// Master drives the request side; the slave returns data and terminations.
interface wb_burst_ram_if #(
  parameter int unsigned AW = 32
) ();
  logic [AW-1:0] adr;
  logic [31:0]   dat_wr;
  logic [31:0]   dat_rd;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output adr, dat_wr, sel, we, cyc, stb, cti, bte,
    input  dat_rd, ack, err, rty
  );

  modport slave (
    input  adr, dat_wr, sel, we, cyc, stb, cti, bte,
    output dat_rd, ack, err, rty
  );
endinterface

// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port RAM slave with registered ack and CTI/BTE burst support.
// Bursts sustain one beat per cycle; classic cycles take two cycles per access.
module wb_burst_ram #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 32,
  parameter string       MEMFILE = ""
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  wb_burst_ram_if.slave wb
);

  localparam int unsigned IW = $clog2(DEPTH);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [31:0]   mem [DEPTH];

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] adr_q, adr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  // Set once an out-of-range request has been errored; cleared when req drops.
  logic          errw_q, errw_d;
  logic [31:0]   dat_q;

  logic          req;
  logic          oor;
  logic [IW-1:0] idx;
  logic [IW-1:0] inc;
  logic [IW-1:0] wrap;
  logic [IW-1:0] nxt;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          unused_adr;

  assign req        = wb.cyc & wb.stb;
  assign idx        = wb.adr[IW+1:2];
  assign oor        = |wb.adr[AW-1:IW+2];
  assign inc        = adr_q + {{(IW-1){1'b0}}, 1'b1};
  assign unused_adr = ^wb.adr[1:0];

  // Wrap modes keep the upper index bits and only advance the low 2/3/4 bits.
  always_comb begin
    wrap = inc;
    unique case (wb.bte)
      2'b00: wrap = inc;
      2'b01: wrap = {adr_q[IW-1:2], inc[1:0]};
      2'b10: wrap = {adr_q[IW-1:3], inc[2:0]};
      2'b11: wrap = {adr_q[IW-1:4], inc[3:0]};
      default: wrap = inc;
    endcase
    nxt = (wb.cti == 3'b010) ? wrap : adr_q;
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    errw_d  = errw_q & req;
    rd_en   = 1'b0;
    rd_idx  = adr_q;
    if (!wb.cyc) begin
      state_d = StIdle;
      ack_d   = 1'b0;
      errw_d  = 1'b0;
    end else if (state_q == StIdle) begin
      ack_d = 1'b0;
      if (req && oor) begin
        if (!errw_q && !ack_q) begin
          err_d  = 1'b1;
          errw_d = 1'b1;
        end
      end else if (req && !ack_q) begin
        adr_d  = idx;
        rd_en  = 1'b1;
        rd_idx = idx;
        ack_d  = 1'b1;
        if (wb.cti == 3'b001 || wb.cti == 3'b010) state_d = StBurst;
      end
    end else begin
      if (!req) begin
        ack_d = 1'b0;
      end else if (ack_q) begin
        adr_d  = nxt;
        rd_en  = 1'b1;
        rd_idx = nxt;
        if (wb.cti == 3'b111) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end else begin
        // Re-issue the beat that was pending when the master inserted a wait state.
        ack_d = 1'b1;
        rd_en = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      errw_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      errw_q  <= errw_d;
      if (rd_en) dat_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && ack_q && req && wb.we) begin
      for (int i = 0; i < 4; i++) begin
        if (wb.sel[i]) mem[adr_q][8*i +: 8] <= wb.dat_wr[8*i +: 8];
      end
    end
  end

  assign wb.dat_rd = dat_q;
  assign wb.ack    = ack_q;
  assign wb.err    = err_q;
  assign wb.rty    = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram.sv
// Randomised self-checking bench for wb_burst_ram against a word-array reference model.
module tb_wb_burst_ram;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_burst_ram_if #(.AW(32)) bus ();

  wb_burst_ram #(
    .DEPTH   (DEPTH),
    .AW      (32),
    .MEMFILE ("")
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Next word of a burst: constant address, or +1 modulo the wrap span.
  function automatic int next_word(input int w, input logic [1:0] bte, input bit cst);
    int span;
    if (cst) return w;
    span = (bte == 2'd0) ? int'(DEPTH) : (2 << bte);
    return (w - w % span) + (w % span + 1) % span;
  endfunction

  task automatic bus_idle();
    bus.cyc    = 1'b0;
    bus.stb    = 1'b0;
    bus.we     = 1'b0;
    bus.cti    = 3'b000;
    bus.bte    = 2'b00;
    bus.sel    = 4'h0;
    bus.adr    = '0;
    bus.dat_wr = '0;
  endtask

  // Leaves the request asserted so a following access can chain back-to-back.
  task automatic classic(input logic [31:0] a, input bit we, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    bus.adr    = a;
    bus.we     = we;
    bus.dat_wr = d;
    bus.sel    = s;
    bus.cti    = 3'b000;
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    tick();
    check("cl_ack", 32'(bus.ack), 32'd1);
    rd = bus.dat_rd;
    if (!we) check("cl_rdata", rd, model[widx(a)]);
    tick();
    if (we) model[widx(a)] = merge(model[widx(a)], d, s);
    check("cl_ack_low", 32'(bus.ack), 32'd0);
  endtask

  task automatic oor_access(input logic [31:0] a, input bit we);
    bus.adr    = a;
    bus.we     = we;
    bus.dat_wr = $urandom();
    bus.sel    = 4'hF;
    bus.cti    = 3'b000;
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    tick();
    check("oor_err", 32'(bus.err), 32'd1);
    check("oor_noack", 32'(bus.ack), 32'd0);
    tick();
    check("oor_err_pulse", 32'(bus.err), 32'd0);
    bus_idle();
    tick();
  endtask

  task automatic burst(input int start, input int n, input logic [1:0] bte, input bit cst,
                       input bit we, input bit full_sel, input int gap_after,
                       input int gap_len, input int abort_at, input bit abort_rst);
    int w;
    int cnt;
    logic [31:0] d;
    logic [3:0]  s;
    w       = start;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = we;
    bus.bte = bte;
    for (int k = 0; k < n; k++) begin
      d          = $urandom();
      s          = full_sel ? 4'hF : 4'($urandom_range(1, 15));
      bus.adr    = 32'(w) << 2;
      bus.dat_wr = d;
      bus.sel    = s;
      bus.cti    = (k == n - 1) ? 3'b111 : (cst ? 3'b001 : 3'b010);
      cnt = 0;
      while (!bus.ack && cnt < 4) begin
        tick();
        cnt++;
      end
      check("bst_ack", 32'(bus.ack), 32'd1);
      if (!we) check("bst_rdata", bus.dat_rd, model[w]);
      if (k == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else bus.cyc = 1'b0;
        tick();
        check("abort_ack", 32'(bus.ack), 32'd0);
        if (abort_rst) check("abort_dat", bus.dat_rd, 32'd0);
        rst = 1'b0;
        bus_idle();
        tick();
        return;
      end
      tick();
      if (we) model[w] = merge(model[w], d, s);
      w = next_word(w, bte, cst);
      if (k == gap_after) begin
        bus.stb = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_ack", 32'(bus.ack), 32'd0);
        end
        bus.stb = 1'b1;
      end
    end
    check("bst_end_ack", 32'(bus.ack), 32'd0);
    bus_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int op;
    int n;
    bus_idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_dat", bus.dat_rd, 32'd0);
    check("rst_rty", 32'(bus.rty), 32'd0);
    rst = 1'b0;
    tick();

    // Fill the whole RAM so every later read has a known expectation.
    burst(0, DEPTH, 2'b00, 1'b0, 1'b1, 1'b1, -1, 0, -1, 1'b0);

    // Classic write then read of 0x10, chained with one idle-ack cycle between.
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd);
    classic(32'h10, 1'b0, 32'h0, 4'hF, rd);
    check("t1_rdata", rd, 32'hDEADBEEF);
    bus_idle();
    tick();

    // Byte-lane write into a known word.
    classic(32'h20, 1'b1, 32'h11223344, 4'hF, rd);
    classic(32'h20, 1'b1, 32'h0000AB00, 4'b0010, rd);
    classic(32'h20, 1'b0, 32'h0, 4'hF, rd);
    check("t2_rdata", rd, 32'h1122AB44);
    bus_idle();
    tick();

    // Wrap4 incrementing read from 0x08: words 2,3,0,1.
    burst(2, 4, 2'b01, 1'b0, 1'b0, 1'b0, -1, 0, -1, 1'b0);

    // Linear 8-beat write with a 2-cycle wait state, then read back.
    burst(0, 8, 2'b00, 1'b0, 1'b1, 1'b1, 2, 2, -1, 1'b0);
    for (int i = 0; i < 8; i++) classic(32'(i) << 2, 1'b0, 32'h0, 4'hF, rd);
    bus_idle();
    tick();

    // Out-of-range read and write; RAM must stay unchanged.
    oor_access(32'h00000400, 1'b0);
    oor_access(32'h00000404, 1'b1);
    classic(32'h4, 1'b0, 32'h0, 4'hF, rd);
    bus_idle();
    tick();

    // Abort a 16-beat burst by dropping cyc, then by reset; later accesses must work.
    burst(5, 16, 2'b00, 1'b0, 1'b1, 1'b0, -1, 0, 6, 1'b0);
    classic(32'h14, 1'b0, 32'h0, 4'hF, rd);
    bus_idle();
    tick();
    burst(40, 16, 2'b11, 1'b0, 1'b1, 1'b0, -1, 0, 9, 1'b1);
    for (int i = 32; i < 48; i++) classic(32'(i) << 2, 1'b0, 32'h0, 4'hF, rd);
    bus_idle();
    tick();

    // Randomised mix of classic, burst and out-of-range traffic.
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 9));
      a  = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      if (op < 3) begin
        classic(a, 1'b1, $urandom(), 4'($urandom_range(0, 15)), rd);
      end else if (op < 5) begin
        classic(a, 1'b0, 32'h0, 4'hF, rd);
      end else if (op < 9) begin
        n = int'($urandom_range(1, 20));
        burst(widx(a), n, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 1'b0,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
              int'($urandom_range(1, 3)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1,
              1'($urandom_range(0, 1)));
      end else begin
        a[31:10] = 22'($urandom_range(1, 4194303));
        oor_access(a, 1'($urandom_range(0, 1)));
      end
    end
    bus_idle();
    tick();

    for (int i = 0; i < 32; i++) classic(32'($urandom_range(0, DEPTH - 1)) << 2, 1'b0,
                                         32'h0, 4'hF, rd);
    bus_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
